// File: rtl/win3x3_valid_gen_pkg.sv
// Shared definitions for the 3x3 window valid generator: padded-width table, FSM states, tap count.
package win3x3_valid_gen_pkg;

  localparam int WIN_TAPS = 9;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Padded line width per select code; codes 6 and 7 are unused.
  function automatic logic [8:0] sel_to_wp(input logic [2:0] sel);
    logic [8:0] wp;
    case (sel)
      3'd0:    wp = 9'd16;
      3'd1:    wp = 9'd30;
      3'd2:    wp = 9'd58;
      3'd3:    wp = 9'd114;
      3'd4:    wp = 9'd226;
      3'd5:    wp = 9'd450;
      default: wp = 9'd0;
    endcase
    return wp;
  endfunction

  function automatic logic sel_legal(input logic [2:0] sel);
    return sel < 3'd6;
  endfunction

endpackage

// File: rtl/win3x3_valid_gen_if.sv
// Window stream interface between the line buffer / producer and the valid generator.
// Optional coordinate outputs exist only when WIN_COORD_OUT_EN is defined.
interface win3x3_valid_gen_if
  import win3x3_valid_gen_pkg::*;
#(
  parameter int DW    = 8,
  parameter int CNT_W = 9
);
  // Handshake: no backpressure. frame_start is a one-cycle pulse aligned with padded pixel (0,0);
  // win_valid qualifies win_out in the same cycle, win_last only ever rises together with win_valid.
  logic [2:0]             sel;
  logic                   stride2;
  logic                   frame_start;
  logic [WIN_TAPS*DW-1:0] win_in;
  logic [WIN_TAPS*DW-1:0] win_out;
  logic                   win_valid;
  logic                   win_last;
  logic                   frame_done;
  logic                   busy;
  state_e                 state_dbg;
  logic [CNT_W-1:0]       wp_dbg;
`ifdef WIN_COORD_OUT_EN
  logic [CNT_W-1:0]       win_row;
  logic [CNT_W-1:0]       win_col;

  modport master (output sel, stride2, frame_start, win_in,
                  input  win_out, win_valid, win_last, frame_done, busy, state_dbg, wp_dbg,
                         win_row, win_col);
  modport slave  (input  sel, stride2, frame_start, win_in,
                  output win_out, win_valid, win_last, frame_done, busy, state_dbg, wp_dbg,
                         win_row, win_col);
`else
  modport master (output sel, stride2, frame_start, win_in,
                  input  win_out, win_valid, win_last, frame_done, busy, state_dbg, wp_dbg);
  modport slave  (input  sel, stride2, frame_start, win_in,
                  output win_out, win_valid, win_last, frame_done, busy, state_dbg, wp_dbg);
`endif
endinterface

// File: rtl/win3x3_valid_gen_win_pos_cnt.sv
// Column/row position of the padded pixel currently on the line buffer input.
// load places the counter on pixel (0,1) because pixel (0,0) is consumed in the load cycle.
module win_pos_cnt #(
  parameter int CNT_W = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] wp,
  output logic [CNT_W-1:0] col,
  output logic [CNT_W-1:0] row,
  output logic             last_pix
);

  logic col_end;

  assign col_end  = (col == wp - CNT_W'(1));
  assign last_pix = col_end && (row == wp - CNT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (load) begin
      col <= CNT_W'(1);
      row <= '0;
    end else if (en) begin
      if (col_end) begin
        col <= '0;
        row <= last_pix ? '0 : row + CNT_W'(1);
      end else begin
        col <= col + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/win3x3_valid_gen.sv
// Marks real 3x3 convolution windows in the line-buffer output stream (stride 1 or 2).
// Define WIN_COORD_OUT_EN to add output-grid coordinates win_row/win_col.
module win3x3_valid_gen
  import win3x3_valid_gen_pkg::*;
#(
  parameter int DW    = 8,
  parameter int CNT_W = 9
) (
  input logic                clk,
  input logic                rst_n,
  win3x3_valid_gen_if.slave  bus
);

  localparam logic [CNT_W-1:0] TWO = CNT_W'(2);

  state_e                 state;
  logic [CNT_W-1:0]       wp_q;
  logic                   s2_q;
  logic [CNT_W-1:0]       col;
  logic [CNT_W-1:0]       row;
  logic                   last_pix;
  logic                   start;
  logic                   run;
  logic                   pix_ok;
  logic                   at_final;
  logic                   qual;
  logic                   tag_last;
  logic                   q1_valid;
  logic                   q1_last;
  logic [WIN_TAPS*DW-1:0] win_q;
  logic                   valid_q;
  logic                   last_q;
  logic                   done_q;

  assign start = bus.frame_start && sel_legal(bus.sel);
  assign run   = (state == RUN);

  win_pos_cnt #(.CNT_W(CNT_W)) u_pos (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (start),
    .en       (run),
    .wp       (wp_q),
    .col      (col),
    .row      (row),
    .last_pix (last_pix)
  );

  assign pix_ok = (row >= TWO) && (col >= TWO) && (!s2_q || (!row[0] && !col[0]));
  // With stride 2 the corner pixel is off-grid, so the last window is the last even/even pixel.
  assign at_final = s2_q ? ((row == wp_q - TWO) && (col == wp_q - TWO)) : last_pix;
  // In a restart cycle the input pixel belongs to the new frame; only a coinciding final pixel counts.
  assign qual     = run && pix_ok && (!start || last_pix);
  assign tag_last = qual && at_final;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      wp_q  <= '0;
      s2_q  <= 1'b0;
    end else if (start) begin
      state <= RUN;
      wp_q  <= CNT_W'(sel_to_wp(bus.sel));
      s2_q  <= bus.stride2;
    end else if (run && last_pix) begin
      state <= IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q1_valid <= 1'b0;
      q1_last  <= 1'b0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      done_q   <= 1'b0;
      win_q    <= '0;
    end else begin
      q1_valid <= qual;
      q1_last  <= tag_last;
      valid_q  <= q1_valid;
      last_q   <= q1_last;
      done_q   <= last_q;
      win_q    <= bus.win_in;
    end
  end

  assign bus.win_out    = win_q;
  assign bus.win_valid  = valid_q;
  assign bus.win_last   = last_q;
  assign bus.frame_done = done_q;
  assign bus.busy       = run;
  assign bus.state_dbg  = state;
  assign bus.wp_dbg     = wp_q;

`ifdef WIN_COORD_OUT_EN
  logic [CNT_W-1:0] g_row;
  logic [CNT_W-1:0] g_col;
  logic [CNT_W-1:0] q1_row;
  logic [CNT_W-1:0] q1_col;
  logic [CNT_W-1:0] row_q;
  logic [CNT_W-1:0] col_q;

  assign g_row = s2_q ? ((row - TWO) >> 1) : (row - TWO);
  assign g_col = s2_q ? ((col - TWO) >> 1) : (col - TWO);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q1_row <= '0;
      q1_col <= '0;
      row_q  <= '0;
      col_q  <= '0;
    end else begin
      q1_row <= g_row;
      q1_col <= g_col;
      row_q  <= q1_row;
      col_q  <= q1_col;
    end
  end

  assign bus.win_row = row_q;
  assign bus.win_col = col_q;
`endif

endmodule
